hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It generates stall, flush and forwarding selects for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences a multi-cycle data-memory wait through a small FSM with a timeout. Sits beside the datapath and reads stage-tagged register addresses and controls from the four pipeline registers.

## Interface
- WAIT_TIMEOUT, 64: max consecutive MEM_WAIT cycles before `err_timeout` sets.
- CNT_W, 32: width of performance counters.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- rs1_addr_D, rs2_addr_D  in  5  source regs of instruction in D.
- rs1_addr_E, rs2_addr_E  in  5  source regs of instruction in E.
- rd_addr_E, rd_addr_M, rd_addr_W  in  5  destination regs per stage.
- rd_wren_E, rd_wren_M, rd_wren_W  in  1  register write enables per stage.
- wb_sel_E  in  2  write-back select in E; WB_MEM marks a load.
- pc_sel_E  in  1  branch/jump taken, resolved in E.
- dmem_req_M  in  1  load/store active in M.
- dmem_ready  in  1  data memory completes access this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1  hold PC / corresponding pipeline register.
- flush_D, flush_E, flush_W  out  1  load bubble (all-zero, rd_wren=0) into that register.
- fwd_a_E, fwd_b_E  out  2  operand source select for E.
- state_o  out  1  FSM state (RUN=0, MEM_WAIT=1).
- err_timeout  out  1  sticky, cleared only by reset.
- stall_cnt, flush_cnt  out  CNT_W  performance counters, wrap at 2^CNT_W.

## Operation
- Forwarding for each operand:
  - M match → 2'b01 (alu_data_M).
  - Else W match → 2'b10 (write-back data).
  - Else 2'b00 (regfile).
  - A match requires rd_wren set, rd≠0 and rd equal to rs. M has priority over W.
- Load-use: rd_wren_E & wb_sel_E==WB_MEM & rd_addr_E≠0 & rd_addr_E∈{rs1_addr_D, rs2_addr_D} → stall_F, stall_D, flush_E for that cycle.
- Branch: pc_sel_E → flush_D, flush_E. Overrides load-use, because the D instruction is wrong-path.
- Memory wait: dmem_req_M & ~dmem_ready → stall_F/D/E/M, flush_W. Highest priority; suppresses branch and load-use actions, which re-evaluate once released.
- FSM:
  - RUN → MEM_WAIT when dmem_req_M & ~dmem_ready.
  - MEM_WAIT → RUN when dmem_ready.
  - Stall outputs are driven combinationally from the condition, not from the state, so the first wait cycle stalls too.
- Timeout: the wait counter increments each MEM_WAIT cycle and clears in RUN. When it reaches WAIT_TIMEOUT, err_timeout sets. Stalling continues; there is no forced release.
- stall_cnt increments on any cycle with stall_F=1.
- flush_cnt increments on each cycle with pc_sel_E & ~memory wait.

## Timing
- Stall, flush and forward outputs are combinational from inputs, available in the same cycle.
- state_o, err_timeout and the counters are registered and update on the rising edge of i_clk.
- While i_rst=1:
  - All stalls=0, flush_D/E/W=1, fwd=2'b00.
  - On the next edge: state=RUN, wait counter=0, err_timeout=0, counters=0.
- Reset mid-MEM_WAIT returns the FSM to RUN on that edge.
- Simultaneous dmem_ready and a new dmem_req_M stays in RUN, with no stall.
- Load-use stall lasts exactly one cycle. The following cycle the load is in M, and forwarding selects 2'b01 only if it is a non-load. Load data reaches E via W (2'b10).

## Structure
- Package hazard_pkg holds:
  - wb_sel constants: WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10.
  - fwd_sel enum: FWD_RF, FWD_M, FWD_W.
  - FSM state enum.
- Sub-module forward_unit: purely combinational forwarding for one operand, instantiated twice.

## Test plan
- rd_addr_M=5, rd_wren_M=1, rd_addr_W=5, rd_wren_W=1, rs1_addr_E=5 → fwd_a_E=2'b01. With rd_addr_M=0 instead → 2'b10.
- Load in E with rd_addr_E=7, rs2_addr_D=7 → stall_F=stall_D=flush_E=1 for one cycle only; stall_cnt +1.
- Load-use plus pc_sel_E=1 in the same cycle → flush_D=flush_E=1, stall_F=0, flush_cnt +1.
- dmem_req_M=1, dmem_ready low for 3 cycles → state_o=1 for cycles 2–4, all stalls and flush_W=1 for 3 cycles, stall_cnt=3.
- dmem_ready held low 64 cycles → err_timeout=1 after the 64th cycle; stays 1 after ready until i_rst.
- Assert i_rst during MEM_WAIT → state_o=0, counters=0 after the edge, flush outputs=1 while i_rst is high.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by hazard_ctrl and forward_unit.
package hazard_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand forwarding select for one E-stage source register.
// M has priority over W; x0 never forwards.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic [4:0] rd_addr_M,
    input  logic       rd_wren_M,
    input  logic [4:0] rd_addr_W,
    input  logic       rd_wren_W,
    output fwd_sel_e   fwd_sel
);

    logic hit_m;
    logic hit_w;

    assign hit_m = rd_wren_M && (rd_addr_M != 5'd0)
                && (rd_addr_M == rs_addr);
    assign hit_w = rd_wren_W && (rd_addr_W != 5'd0)
                && (rd_addr_W == rs_addr);

    // Youngest producer wins.
    always_comb begin
        fwd_sel = FWD_RF;
        if (hit_m) begin
            fwd_sel = FWD_M;
        end else if (hit_w) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding,
// data-memory wait FSM with timeout and perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_addr_E,
    input  logic [4:0]       rd_addr_M,
    input  logic [4:0]       rd_addr_W,
    input  logic             rd_wren_E,
    input  logic             rd_wren_M,
    input  logic             rd_wren_W,
    input  logic [1:0]       wb_sel_E,
    input  logic             pc_sel_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       fwd_a_E,
    output logic [1:0]       fwd_b_E,
    output logic             state_o,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_TIMEOUT);

    hz_state_e       state_q;
    hz_state_e       state_nx;
    logic [WC_W-1:0] wait_cnt_q;
    logic [WC_W-1:0] wait_cnt_nx;
    logic            mem_wait;
    logic            load_use;
    fwd_sel_e        fwd_a;
    fwd_sel_e        fwd_b;

    forward_unit u_fwd_a (
        .rs_addr   (rs1_addr_E),
        .rd_addr_M (rd_addr_M),
        .rd_wren_M (rd_wren_M),
        .rd_addr_W (rd_addr_W),
        .rd_wren_W (rd_wren_W),
        .fwd_sel   (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_addr   (rs2_addr_E),
        .rd_addr_M (rd_addr_M),
        .rd_wren_M (rd_wren_M),
        .rd_addr_W (rd_addr_W),
        .rd_wren_W (rd_wren_W),
        .fwd_sel   (fwd_b)
    );

    assign mem_wait = dmem_req_M && !dmem_ready;
    assign load_use = rd_wren_E && (wb_sel_E == WB_MEM)
                   && (rd_addr_E != 5'd0)
                   && ((rd_addr_E == rs1_addr_D)
                    || (rd_addr_E == rs2_addr_D));

    assign state_o = state_q;

    // Stall/flush priority: reset, memory wait, branch, load-use.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        fwd_a_E = fwd_a;
        fwd_b_E = fwd_b;
        if (i_rst) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_W = 1'b1;
            fwd_a_E = FWD_RF;
            fwd_b_E = FWD_RF;
        end else if (mem_wait) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
        end else if (pc_sel_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    // Next state and wait counter; the counter tracks cycles
    // that end in MEM_WAIT and saturates at the timeout.
    always_comb begin
        state_nx    = state_q;
        wait_cnt_nx = '0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_wait) state_nx = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
        if (state_nx == ST_MEM_WAIT) begin
            if (wait_cnt_q == WC_MAX) begin
                wait_cnt_nx = wait_cnt_q;
            end else begin
                wait_cnt_nx = wait_cnt_q + WC_W'(1);
            end
        end
    end

    // State, sticky timeout flag and performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state_q    <= state_nx;
            wait_cnt_q <= wait_cnt_nx;
            if (wait_cnt_nx == WC_MAX) begin
                err_timeout <= 1'b1;
            end
            if (stall_F) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pc_sel_E && !mem_wait) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
